// File: rtl/lcd_char_feeder.sv
// rtl/lcd_char_feeder.sv - LCD controller front end: startup sequencing, character FIFO, paced sends
module lcd_char_feeder #(
    parameter int FIFO_DEPTH   = 16,
    parameter int START_DELAY  = 1000,
    parameter int READY_CYCLES = 200000,
    parameter int CHAR_GAP     = 2000,
    parameter bit FILTER       = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          lcd_init,
    output logic                          lcd_enviar,
    output logic [7:0]                    lcd_info,
    output logic                          lcd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    char_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {BOOT, INIT, CFG_WAIT, IDLE, SEND, GAP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   timer_q, timer_d;
    logic          ready_q, ready_d;
    logic [7:0]    info_q, info_d;
    logic [7:0]    cc_q, cc_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic storable;
    logic push;
    logic pop;

    // Non-printable bytes are still consumed so the source never stalls on them.
    always_comb begin
        storable = !FILTER || ((in_data >= 8'h20) && (in_data <= 8'h7E));
        in_ready = (count_q != CW'(FIFO_DEPTH));
        push     = in_valid && in_ready && storable;
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 32'd1;
        ready_d    = ready_q;
        info_d     = info_q;
        cc_d       = cc_q;
        pop        = 1'b0;
        lcd_init   = 1'b0;
        lcd_enviar = 1'b0;
        case (state_q)
            BOOT: begin
                if (timer_q == 32'(START_DELAY - 1)) state_d = INIT;
            end
            INIT: begin
                lcd_init = 1'b1;
                state_d  = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (timer_q == 32'(READY_CYCLES - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                // Load the head now so it is already on lcd_info during the send pulse.
                if (count_q != '0) begin
                    state_d = SEND;
                    info_d  = mem_q[rd_q];
                    cc_d    = cc_q + 8'd1;
                end
            end
            SEND: begin
                lcd_enviar = 1'b1;
                pop        = 1'b1;
                state_d    = GAP;
            end
            GAP: begin
                if (timer_q == 32'(CHAR_GAP - 1)) state_d = IDLE;
            end
            default: state_d = BOOT;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    always_comb begin
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            timer_q <= '0;
            ready_q <= 1'b0;
            info_q  <= 8'h00;
            cc_q    <= 8'h00;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ready_q <= ready_d;
            info_q  <= info_d;
            cc_q    <= cc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_data;
    end

    assign lcd_info   = info_q;
    assign lcd_ready  = ready_q;
    assign fifo_count = count_q;
    assign char_count = cc_q;

endmodule

// File: tb/tb_lcd_char_feeder.sv
// tb/tb_lcd_char_feeder.sv - self-checking bench for lcd_char_feeder against a cycle-count model
module tb_lcd_char_feeder;

    localparam int DEPTH = 4;
    localparam int SD    = 4;
    localparam int RC    = 20;
    localparam int GAPC  = 8;
    localparam int RDY   = SD + 1 + RC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, lcd_init, lcd_enviar, lcd_ready;
    logic [7:0] lcd_info, char_count;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    lcd_char_feeder #(
        .FIFO_DEPTH(DEPTH), .START_DELAY(SD), .READY_CYCLES(RC), .CHAR_GAP(GAPC), .FILTER(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .lcd_init(lcd_init), .lcd_enviar(lcd_enviar), .lcd_info(lcd_info), .lcd_ready(lcd_ready),
        .fifo_count(fifo_count), .char_count(char_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: cycle index since reset release, queue of stored bytes, time of last send.
    bit         mvalid = 1'b0;
    int         cyc = 0;
    int         last_send = -1000;
    logic [7:0] q[$];
    logic [7:0] m_info = 8'h00;
    logic [7:0] m_cc = 8'h00;
    bit         m_send = 1'b0;

    logic [7:0] send_log[$];
    int         send_cyc[$];
    int         init_cyc = -1, init_cnt = 0, ready_cyc = -1, max_fc = 0, prev_pulse = -1;
    int         min_gap = 1 << 30;
    logic [7:0] cc_at_256 = 8'hFF;

    function automatic bit printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    always @(negedge clk) begin
        int qs;
        int gap;
        bit sn;
        bit acc;
        if (mvalid) begin
            chk("lcd_init", lcd_init, cyc == SD);
            chk("lcd_ready", lcd_ready, cyc >= RDY);
            chk("lcd_enviar", lcd_enviar, m_send);
            chk("lcd_info", lcd_info, m_info);
            chk("char_count", char_count, m_cc);
            chk("fifo_count", fifo_count, q.size());
            chk("in_ready", in_ready, q.size() < DEPTH);
            if (lcd_init) begin init_cnt++; init_cyc = cyc; end
            if (lcd_ready && ready_cyc < 0) ready_cyc = cyc;
            if (int'(fifo_count) > max_fc) max_fc = int'(fifo_count);
            if (lcd_enviar) begin
                if (prev_pulse >= 0) begin
                    gap = cyc - prev_pulse;
                    if (gap < min_gap) min_gap = gap;
                    chk("pulse_spacing_ok", gap >= GAPC + 2, 1);
                end
                prev_pulse = cyc;
                send_log.push_back(lcd_info);
                send_cyc.push_back(cyc);
                if (send_log.size() == 256) cc_at_256 = char_count;
            end
        end
        if (reset) begin
            mvalid = 1'b1; cyc = 0; last_send = -1000; q.delete();
            m_info = 8'h00; m_cc = 8'h00; m_send = 1'b0;
            send_log.delete(); send_cyc.delete();
            init_cyc = -1; init_cnt = 0; ready_cyc = -1; prev_pulse = -1;
        end else if (mvalid) begin
            qs  = q.size();
            sn  = !m_send && (cyc >= RDY) && (cyc >= last_send + GAPC + 1) && (qs != 0);
            acc = in_valid && (qs < DEPTH);
            if (m_send) void'(q.pop_front());
            if (acc && printable(in_data)) q.push_back(in_data);
            if (sn) begin
                m_info = q[0];
                m_cc = m_cc + 8'd1;
                last_send = cyc + 1;
            end
            m_send = sn;
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        in_valid = 1'b0;
        tick(n);
        reset = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, output int acc_c, output bit ok);
        in_valid = 1'b1;
        in_data = b;
        ok = 1'b0;
        acc_c = -1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1;
            if (in_ready) begin ok = 1'b1; acc_c = cyc - 1; end
            @(posedge clk); #1;
        end
        chk("push_handshake", ok, 1);
    endtask

    task automatic wait_sends(input int n, input int budget, input string name);
        for (int i = 0; i < budget && send_log.size() < n; i++) tick(1);
        chk(name, send_log.size() >= n, 1);
    endtask

    initial begin
        int  a0, a1, a_last;
        bit  ok;

        do_reset(3);
        tick(RDY + 5);
        chk("t1_init_count", init_cnt, 1);
        chk("t1_init_cycle", init_cyc, 4);
        chk("t1_ready_cycle", ready_cyc, 25);
        chk("t1_no_sends", send_log.size(), 0);
        chk("t1_info_zero", lcd_info, 8'h00);

        push_byte(8'h48, a0, ok);
        push_byte(8'h69, a1, ok);
        in_valid = 1'b0;
        wait_sends(2, 100, "t2_two_sends");
        if (send_log.size() >= 2) begin
            chk("t2_first_char", send_log[0], 8'h48);
            chk("t2_second_char", send_log[1], 8'h69);
            chk("t2_spacing", send_cyc[1] - send_cyc[0], 10);
            chk("t2_latency", send_cyc[0] - a0, 2);
        end
        chk("t2_char_count", char_count, 8'd2);

        do_reset(2);
        for (int k = 0; k < 5; k++) push_byte(8'(8'h41 + k), a_last, ok);
        in_valid = 1'b0;
        wait_sends(5, 200, "t3_five_sends");
        for (int k = 0; k < 5 && k < send_log.size(); k++)
            chk("t3_order", send_log[k], 8'(8'h41 + k));
        if (send_log.size() >= 1) begin
            chk("t3_first_send_cycle", send_cyc[0], 26);
            chk("t3_fifth_accept", a_last, send_cyc[0] + 1);
        end

        tick(12);
        max_fc = 0;
        push_byte(8'h0A, a0, ok);
        push_byte(8'h7F, a0, ok);
        push_byte(8'h5A, a0, ok);
        in_valid = 1'b0;
        wait_sends(6, 100, "t4_one_send");
        tick(30);
        chk("t4_total_sends", send_log.size(), 6);
        if (send_log.size() >= 6) chk("t4_char", send_log[5], 8'h5A);
        chk("t4_peak_count", max_fc, 1);

        push_byte(8'h31, a0, ok);
        push_byte(8'h32, a0, ok);
        push_byte(8'h33, a0, ok);
        in_valid = 1'b0;
        wait_sends(7, 100, "t5_first_send");
        tick(3);
        chk("t5_queued_before_reset", fifo_count, 3'd2);
        do_reset(2);
        chk("t5_fifo_count", fifo_count, 3'd0);
        chk("t5_info", lcd_info, 8'h00);
        chk("t5_char_count", char_count, 8'h00);
        chk("t5_ready", lcd_ready, 1'b0);
        chk("t5_in_ready", in_ready, 1'b1);
        tick(RDY + 30);
        chk("t5_reinit_count", init_cnt, 1);
        chk("t5_reinit_cycle", init_cyc, 4);
        chk("t5_no_stale", send_log.size(), 0);

        for (int i = 0; i < 8000 && send_log.size() < 256; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(32, 126));
            tick(1);
        end
        in_valid = 1'b0;
        chk("t6_256_sent", send_log.size() >= 256, 1);
        chk("t6_wrap", cc_at_256, 8'h00);
        chk("t6_min_gap", min_gap, 10);
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
